slow_clock_meter: RTL and testbench

Measures the period and high time of a slow, asynchronous square wave (nominally a divided 1 Hz clock) in cycles of the system clock `clock_in`. It checks the period against an expected value and flags loss of the input. It sits alongside the clock divider as its consumer and self-check: the divider generates the slow clock, and this block reads it back and reports whether it is alive and on frequency.

---
 rtl/slow_clock_meter_pkg.sv | 7 +
 rtl/slow_clock_meter_sync_edge.sv | 39 +++
 rtl/slow_clock_meter.sv | 141 ++++++++++++++
 tb/tb_slow_clock_meter.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/slow_clock_meter_pkg.sv
// Shared constants for the slow clock meter: depth of the metastability
// synchronizer that brings the slow input into the clock_in domain.
package slow_clock_meter_pkg;

    localparam int unsigned SYNC_STAGES = 2;

endpackage

// File: rtl/slow_clock_meter_sync_edge.sv
// Synchronizes an asynchronous level into the local clock domain and reports
// its level plus single-cycle rise/fall strobes.
module sync_edge
    import slow_clock_meter_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   prev_q;
    logic                   prev_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], d};
        prev_d = sync_q[SYNC_STAGES-1];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    // Edge strobes compare the synchronized level against its one-cycle-old copy.
    assign level = sync_q[SYNC_STAGES-1];
    assign rise  = sync_q[SYNC_STAGES-1] & ~prev_q;
    assign fall  = ~sync_q[SYNC_STAGES-1] & prev_q;

endmodule

// File: rtl/slow_clock_meter.sv
// Measures period and high time of a slow asynchronous square wave in clock_in
// cycles, checks the period against EXPECTED +/- TOLERANCE and flags loss.
module slow_clock_meter #(
    parameter int unsigned          WIDTH     = 28,
    parameter logic [WIDTH-1:0]     EXPECTED  = 28'd50000000,
    parameter logic [WIDTH-1:0]     TOLERANCE = 28'd1000,
    parameter logic [WIDTH-1:0]     TIMEOUT   = 28'd100000000
) (
    input  logic             clock_in,
    input  logic             reset,
    input  logic             slow_in,
    output logic [WIDTH-1:0] period_out,
    output logic [WIDTH-1:0] high_out,
    output logic             valid,
    output logic             in_range,
    output logic             timeout
);

    typedef enum logic {
        IDLE    = 1'b0,
        MEASURE = 1'b1
    } state_e;

    localparam logic [WIDTH-1:0] ONE          = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] TIMEOUT_LAST = TIMEOUT - ONE;
    // Window bounds carry one extra bit so EXPECTED +/- TOLERANCE cannot wrap.
    localparam logic [WIDTH:0]   WIN_LO = {1'b0, EXPECTED} - {1'b0, TOLERANCE};
    localparam logic [WIDTH:0]   WIN_HI = {1'b0, EXPECTED} + {1'b0, TOLERANCE};

    logic slow_rise;
    logic slow_fall;
    logic slow_level_unused;

    sync_edge u_sync (
        .clk   (clock_in),
        .rst   (reset),
        .d     (slow_in),
        .level (slow_level_unused),
        .rise  (slow_rise),
        .fall  (slow_fall)
    );

    state_e           state_q,     state_d;
    logic [WIDTH-1:0] cnt_q,       cnt_d;
    logic [WIDTH-1:0] high_pend_q, high_pend_d;
    logic             pend_q,      pend_d;
    logic [WIDTH-1:0] period_q,    period_d;
    logic [WIDTH-1:0] high_q,      high_d;
    logic             valid_q,     valid_d;
    logic             in_range_q,  in_range_d;
    logic             timeout_q,   timeout_d;

    logic [WIDTH-1:0] cnt_inc;
    logic [WIDTH:0]   cnt_inc_ext;
    logic             window_ok;

    always_comb begin
        cnt_inc     = cnt_q + ONE;
        cnt_inc_ext = {1'b0, cnt_q} + {1'b0, ONE};
        window_ok   = (cnt_inc_ext >= WIN_LO) && (cnt_inc_ext <= WIN_HI);
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        high_pend_d = high_pend_q;
        pend_d      = pend_q;
        period_d    = period_q;
        high_d      = high_q;
        valid_d     = 1'b0;
        in_range_d  = in_range_q;
        timeout_d   = timeout_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (slow_rise) begin
                    state_d = MEASURE;
                    pend_d  = 1'b0;
                end
            end
            MEASURE: begin
                if (slow_fall) begin
                    high_pend_d = cnt_inc;
                    pend_d      = 1'b1;
                end
                if (slow_rise) begin
                    period_d   = cnt_inc;
                    high_d     = pend_q ? high_pend_q : cnt_inc;
                    valid_d    = 1'b1;
                    in_range_d = window_ok;
                    timeout_d  = 1'b0;
                    cnt_d      = '0;
                    pend_d     = 1'b0;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    // Input lost: keep the last measurement, restart from IDLE.
                    timeout_d  = 1'b1;
                    in_range_d = 1'b0;
                    state_d    = IDLE;
                    cnt_d      = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            high_pend_q <= '0;
            pend_q      <= 1'b0;
            period_q    <= '0;
            high_q      <= '0;
            valid_q     <= 1'b0;
            in_range_q  <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            high_pend_q <= high_pend_d;
            pend_q      <= pend_d;
            period_q    <= period_d;
            high_q      <= high_d;
            valid_q     <= valid_d;
            in_range_q  <= in_range_d;
            timeout_q   <= timeout_d;
        end
    end

    assign period_out = period_q;
    assign high_out   = high_q;
    assign valid      = valid_q;
    assign in_range   = in_range_q;
    assign timeout    = timeout_q;

endmodule

// File: tb/tb_slow_clock_meter.sv
// Bench for slow_clock_meter: directed and random square waves checked every
// cycle against an event-based model of edges seen three cycles after driving.
module tb_slow_clock_meter;

    localparam int W       = 28;
    localparam int EXP_P   = 10;
    localparam int TOL     = 1;
    localparam int TMO     = 40;
    localparam int LAT     = 3;

    logic          clock_in = 1'b0;
    logic          reset    = 1'b1;
    logic          slow_in  = 1'b0;
    logic [W-1:0]  period_out;
    logic [W-1:0]  high_out;
    logic          valid;
    logic          in_range;
    logic          timeout;

    slow_clock_meter #(
        .WIDTH     (W),
        .EXPECTED  (28'd10),
        .TOLERANCE (28'd1),
        .TIMEOUT   (28'd40)
    ) dut (
        .clock_in   (clock_in),
        .reset      (reset),
        .slow_in    (slow_in),
        .period_out (period_out),
        .high_out   (high_out),
        .valid      (valid),
        .in_range   (in_range),
        .timeout    (timeout)
    );

    always #5 clock_in = ~clock_in;

    typedef struct {
        int due;
        bit is_rise;
    } ev_t;

    ev_t ev_q[$];
    int  cycle = 0;
    int  tests = 0;
    int  fails = 0;

    bit  m_meas, m_fall_seen;
    int  m_rise_t, m_fall_t;
    int  m_period, m_high;
    bit  m_valid, m_in_range, m_timeout;

    task automatic model_clear();
        ev_q.delete();
        m_meas = 0; m_fall_seen = 0;
        m_rise_t = 0; m_fall_t = 0;
        m_period = 0; m_high = 0;
        m_valid = 0; m_in_range = 0; m_timeout = 0;
    endtask

    // Edges take effect LAT cycles after being driven; a rise closes a period.
    task automatic model_step();
        ev_t e;
        m_valid = 0;
        while (ev_q.size() > 0 && ev_q[0].due == cycle) begin
            e = ev_q.pop_front();
            if (e.is_rise) begin
                if (m_meas) begin
                    m_period   = cycle - m_rise_t;
                    m_high     = m_fall_seen ? (m_fall_t - m_rise_t) : m_period;
                    m_valid    = 1;
                    m_in_range = (m_period >= EXP_P - TOL) && (m_period <= EXP_P + TOL);
                    m_timeout  = 0;
                end
                m_meas = 1; m_rise_t = cycle; m_fall_seen = 0;
            end else if (m_meas) begin
                m_fall_seen = 1; m_fall_t = cycle;
            end
        end
        if (m_meas && (cycle - m_rise_t) == TMO) begin
            m_timeout = 1; m_in_range = 0; m_meas = 0;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s @cycle %0d: observed %0d expected %0d", tag, cycle, obs, exp);
        end
    endtask

    task automatic check_outputs();
        chk("valid",    {31'd0, valid},    {31'd0, m_valid});
        chk("timeout",  {31'd0, timeout},  {31'd0, m_timeout});
        chk("in_range", {31'd0, in_range}, {31'd0, m_in_range});
        chk("period",   {4'd0, period_out}, m_period);
        chk("high",     {4'd0, high_out},   m_high);
    endtask

    task automatic tick();
        @(posedge clock_in);
        #1;
        cycle++;
        if (!reset) model_step();
        check_outputs();
    endtask

    task automatic set_slow(input logic v);
        ev_t e;
        if (v != slow_in && !reset) begin
            e.due = cycle + LAT;
            e.is_rise = v;
            ev_q.push_back(e);
        end
        slow_in = v;
    endtask

    task automatic assert_reset();
        reset = 1'b1;
        model_clear();
        #1;
        check_outputs();
    endtask

    task automatic release_reset();
        ev_t e;
        reset = 1'b0;
        if (slow_in) begin
            e.due = cycle + LAT;
            e.is_rise = 1'b1;
            ev_q.push_back(e);
        end
    endtask

    task automatic wave(input int h, input int l, input int n);
        for (int k = 0; k < n; k++) begin
            set_slow(1'b1);
            repeat (h) tick();
            set_slow(1'b0);
            repeat (l) tick();
        end
    endtask

    initial begin
        model_clear();
        // Reset held while the input toggles: everything stays at zero.
        #1;
        check_outputs();
        for (int i = 0; i < 12; i++) begin
            set_slow(i[1]);
            tick();
        end
        set_slow(1'b0);
        release_reset();
        repeat (3) tick();

        // Nominal, then off-frequency periods.
        wave(5, 5, 6);
        wave(6, 6, 4);
        wave(4, 7, 4);

        // Loss of input after a rise, then recovery.
        set_slow(1'b1);
        repeat (5) tick();
        set_slow(1'b0);
        repeat (60) tick();
        wave(5, 5, 4);

        // Reset while measuring with cnt at 7.
        set_slow(1'b1);
        repeat (LAT + 7) tick();
        assert_reset();
        for (int i = 0; i < 6; i++) begin
            set_slow(i[0]);
            tick();
        end
        set_slow(1'b0);
        release_reset();
        repeat (3) tick();
        wave(5, 5, 6);

        // Random high/low lengths straddling the tolerance window.
        for (int i = 0; i < 40; i++) begin
            wave($urandom_range(1, 12), $urandom_range(1, 12), 1);
        end
        repeat (50) tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
